// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer that borrows the CPU's shared ALU.
// While busy it stalls the CPU, muxes itself onto the ALU inputs and issues one
// ALU add per multiplier bit, terminating early once the remaining multiplier is zero.
// Optional feature macro: MUL_SIGNED_EN enables the two's-complement path
// (IDLE -> NEGA -> NEGB -> LOOP -> FIX -> DONE). ALU op 110 is assumed to return -alu_a.
module alu_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             signed_op_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o,
  output logic             mul_ovf_o,
  output logic             alu_sel_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [2:0]       alu_op_o,
  output logic             alu_s_inm_o,
  input  logic [WIDTH-1:0] alu_y_i
);

  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpAdd  = 3'b010;

`ifdef MUL_SIGNED_EN
  localparam logic [2:0]       OpNeg  = 3'b110;
  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StLoop, StDone, StNegA, StNegB, StFix
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle, StLoop, StDone
  } state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mc_q;
  logic [WIDTH-1:0] mp_q;
  logic             ovf_q;
  logic [WIDTH-1:0] product_q;
  logic             mul_ovf_q;
  logic             busy_q;
  logic             done_q;

`ifdef MUL_SIGNED_EN
  logic neg_q;     // result sign: sign(mcand) ^ sign(mplier)
  logic signed_q;  // current request takes the signed path
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op_i;
`endif

  // Sequencer FSM: operand capture, shift-and-add loop, result hand-off.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mc_q      <= '0;
      mp_q      <= '0;
      ovf_q     <= 1'b0;
      product_q <= '0;
      mul_ovf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MUL_SIGNED_EN
      neg_q     <= 1'b0;
      signed_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            mc_q   <= mcand_i;
            mp_q   <= mplier_i;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
`ifdef MUL_SIGNED_EN
            neg_q    <= mcand_i[WIDTH-1] ^ mplier_i[WIDTH-1];
            signed_q <= signed_op_i;
            state_q  <= signed_op_i ? StNegA : StLoop;
`else
            state_q  <= StLoop;
`endif
          end
        end

        StLoop: begin
          if (mp_q == '0) begin
`ifdef MUL_SIGNED_EN
            if (signed_q) begin
              state_q <= StFix;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
`else
            state_q <= StDone;
            done_q  <= 1'b1;
`endif
          end else begin
            if (mp_q[0]) begin
              acc_q <= alu_y_i;
              // Unsigned carry-out of acc + mc, derived locally.
              if (alu_y_i < acc_q) ovf_q <= 1'b1;
            end
            // A set top bit about to be shifted out while multiplier bits remain.
            if (mc_q[WIDTH-1] && ((mp_q >> 1) != '0)) ovf_q <= 1'b1;
            mc_q <= mc_q << 1;
            mp_q <= mp_q >> 1;
          end
        end

`ifdef MUL_SIGNED_EN
        StNegA: begin
          if (mc_q[WIDTH-1]) mc_q <= alu_y_i;
          state_q <= StNegB;
        end

        StNegB: begin
          if (mp_q[WIDTH-1]) mp_q <= alu_y_i;
          state_q <= StLoop;
        end

        StFix: begin
          if (neg_q) acc_q <= alu_y_i;
          // Magnitude with the top bit set only fits as the most negative value.
          if (acc_q[WIDTH-1] && !(neg_q && (acc_q == MinNeg))) ovf_q <= 1'b1;
          state_q <= StDone;
          done_q  <= 1'b1;
        end
`endif

        StDone: begin
          product_q <= acc_q;
          mul_ovf_q <= ovf_q;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // ALU drive decoded from the registered state; alu_y returns in the same cycle.
  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = OpNone;
    case (state_q)
      StLoop: begin
        if (mp_q != '0) begin
          alu_op_o = OpAdd;
          alu_a_o  = acc_q;
          alu_b_o  = mc_q;
        end
      end
`ifdef MUL_SIGNED_EN
      StNegA: begin
        alu_op_o = OpNeg;
        alu_a_o  = mc_q;
      end
      StNegB: begin
        alu_op_o = OpNeg;
        alu_a_o  = mp_q;
      end
      StFix: begin
        alu_op_o = OpNeg;
        alu_a_o  = acc_q;
      end
`endif
      default: begin
        alu_op_o = OpNone;
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign stall_o     = busy_q;
  assign alu_sel_o   = busy_q;
  assign done_o      = done_q;
  assign product_o   = product_q;
  assign mul_ovf_o   = mul_ovf_q;
  assign alu_s_inm_o = 1'b0;

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle shift-and-add multiplier sequencer for the single-cycle CPU. It borrows the shared ALU for integer multiply.
- While active, it stalls the CPU, takes over the ALU operand and opcode inputs through a mux select, and issues one ALU add (op 010) per multiplier bit.
- It holds the product and an overflow flag for the datapath to write back.

Parameters:
- WIDTH, 16, operand, product and ALU data width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- signed_op  in  1  two's-complement multiply request (see Optional Feature)
- mcand_in  in  WIDTH  multiplicand, captured on accepted start
- mplier_in  in  WIDTH  multiplier, captured on accepted start
- busy  out  1  high in every state except IDLE
- stall  out  1  equals busy; freezes PC and register writes
- done  out  1  one-cycle pulse in DONE
- product  out  WIDTH  low WIDTH bits of result; held until next accepted start
- mul_ovf  out  1  result did not fit in WIDTH bits; held with product
- alu_sel  out  1  equals busy; selects sequencer onto ALU inputs
- alu_a  out  WIDTH  ALU operand a
- alu_b  out  WIDTH  ALU operand b
- alu_op  out  3  ALU opcode
- alu_s_inm  out  1  always 0
- alu_y  in  WIDTH  ALU result, combinational in the same cycle

Behaviour:
- Reset: state IDLE; busy, stall, done, alu_sel, mul_ovf = 0; product, alu_a, alu_b = 0; alu_op = 000. Reset mid-operation aborts the multiply and discards partial results.
- Registers: acc (WIDTH), mc (WIDTH), mp (WIDTH), ovf_acc, neg_res.
- IDLE:
  - When start = 1: mc <= mcand_in, mp <= mplier_in, acc <= 0, ovf_acc <= 0. Next state is LOOP, or NEGA in signed mode.
  - start while busy is ignored; no queuing.
- LOOP, one cycle per multiplier bit:
  - If mp == 0, go to DONE (early termination).
  - Otherwise drive alu_op=010, alu_a=acc, alu_b=mc.
  - If mp[0] = 1: acc <= alu_y. Set ovf_acc if alu_y < acc (unsigned carry-out, computed locally; the ALU carry flag is not used).
  - If mc[WIDTH-1] = 1 and (mp>>1) != 0: set ovf_acc.
  - Then mc <= mc<<1 and mp <= mp>>1.
  - At most WIDTH iterations.
- DONE: product <= acc, mul_ovf <= ovf_acc (final values, including FIX), done = 1 for this one cycle, next state IDLE.
- Latency, unsigned, start accepted at cycle T:
  - LOOP occupies T+1 .. T+k+1, where k = index of the highest set bit of mplier_in plus 1 (k = 0 for zero).
  - DONE at T+k+2.
- ALU drive outside LOOP/NEG/FIX states: alu_a = alu_b = 0, alu_op = 000.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined, and start with signed_op = 1, path is IDLE -> NEGA -> NEGB -> LOOP -> FIX -> DONE (+3 cycles):
  - NEGA: alu_op=110, alu_a=mc. If mc[WIDTH-1], mc <= alu_y.
  - NEGB: alu_op=110, alu_a=mp. If mp[WIDTH-1], mp <= alu_y.
  - neg_res <= sign(mcand_in) XOR sign(mplier_in), captured at start.
  - LOOP runs unsigned on the magnitudes.
  - FIX: alu_op=110, alu_a=acc. If neg_res, acc <= alu_y.
  - Signed overflow = ovf_acc, OR magnitude acc[WIDTH-1]=1, except when neg_res and acc == 2^(WIDTH-1).
  - Zero product never overflows. A zero product with neg_res set yields 0.
- Undefined: signed_op is ignored; every request is unsigned. The NEGA/NEGB/FIX states are absent.

Test Plan (WIDTH=16):
1. start at T, mcand=7, mplier=6 -> busy and alu_sel high T+1..T+5; alu_op=010 during LOOP; done at T+5; product=0x002A; mul_ovf=0.
2. mcand=0x1234, mplier=0 -> done at T+2; product=0x0000; mul_ovf=0. Then mcand=0xFFFF, mplier=1 -> product=0xFFFF, mul_ovf=0.
3. mcand=0x0100, mplier=0x0100 -> product=0x0000, mul_ovf=1. mcand=0x8000, mplier=2 -> product=0x0000, mul_ovf=1. mcand=0xFFFF, mplier=0xFFFF -> product=0x0001, mul_ovf=1.
4. Pulse start again during LOOP with different operands -> ignored; first result unchanged. Reset asserted mid-LOOP -> next cycle busy=0, product=0, mul_ovf=0, alu_op=000; no done pulse.
5. With MUL_SIGNED_EN, signed_op=1:
   - -3 x 5 -> product=0xFFF1, mul_ovf=0.
   - 0x8000 x 1 -> 0x8000, mul_ovf=0.
   - 0x8000 x 0xFFFF -> mul_ovf=1.
   - 200 x 200 -> mul_ovf=1.
   - Latency is the unsigned latency plus 3.
6. Back-to-back: new start in the cycle after done -> accepted. product holds the previous value until the second DONE.
